// File: rtl/mc_rf_pkg.sv
// Shared types and defaults for the memory-controller refresh scheduler.
package mc_rf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_START = 2'd2,
    ST_RUN   = 2'd3
  } rf_state_e;

  localparam int          PEND_W_DEF      = 4;
  localparam logic [23:0] TIMEOUT_CYC_DEF = 24'hFF_FFFF;
  localparam int          TMR_W           = 28;
  localparam int          TO_W            = 24;

  // A zero period behaves like a period of one cycle.
  function automatic logic [TMR_W-1:0] reload_val(input logic [TMR_W-1:0] period);
    return (period == '0) ? '0 : period - 1'b1;
  endfunction

endpackage

// File: rtl/mc_rf_timer.sv
// Refresh tick generator: start delay after an enable edge, then a periodic tick.
module mc_rf_timer
  import mc_rf_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [TMR_W-1:0] start_cfg,
  input  logic [TMR_W-1:0] period_cfg,
  output logic             tick
);

  logic             en_reg;
  logic [TMR_W-1:0] tmr_reg;

  // The edge cycle only loads the start delay; ticks begin from the next cycle on.
  assign tick = en && en_reg && (tmr_reg == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_reg  <= 1'b0;
      tmr_reg <= '0;
    end else begin
      en_reg <= en;
      if (!en)
        tmr_reg <= '0;
      else if (!en_reg)
        tmr_reg <= start_cfg;
      else if (tmr_reg == '0)
        tmr_reg <= reload_val(period_cfg);
      else
        tmr_reg <= tmr_reg - 1'b1;
    end
  end

endmodule

// File: rtl/mc_rf_sched.sv
// Refresh scheduler: queues refresh obligations, arbitrates for the array and
// runs the rf_start/rf_finish handshake with a run-time watchdog.
module mc_rf_sched
  import mc_rf_pkg::*;
#(
  parameter int          PEND_W      = PEND_W_DEF,
  parameter logic [23:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mc_rf_en,
  input  logic [27:0]       mc_rf_start_time_cfg,
  input  logic [27:0]       mc_rf_period_time_cfg,
  output logic              rf_req,
  input  logic              rf_gnt,
  output logic              rf_start,
  input  logic              rf_finish,
  output logic              rf_busy,
  output logic [PEND_W-1:0] rf_pend_cnt,
  output logic              rf_overflow,
  output logic              rf_err
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] REQ   = ST_REQ;
  localparam logic [1:0] START = ST_START;
  localparam logic [1:0] RUN   = ST_RUN;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic              tick;
  logic [1:0]        state_reg, state_next;
  logic [PEND_W-1:0] pend_reg;
  logic              ovf_reg, err_reg;
  logic [TO_W-1:0]   to_cnt_reg;
  logic              launch, timeout_hit;

  mc_rf_timer u_timer (
    .clk        (clk),
    .rstn       (rstn),
    .en         (mc_rf_en),
    .start_cfg  (mc_rf_start_time_cfg),
    .period_cfg (mc_rf_period_time_cfg),
    .tick       (tick)
  );

  assign launch      = (state_reg == START);
  assign timeout_hit = (state_reg == RUN) && !rf_finish &&
                       (to_cnt_reg == TIMEOUT_CYC - 24'd1);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mc_rf_en && (pend_reg != '0)) state_next = REQ;
      REQ:     if (!mc_rf_en) state_next = IDLE;
               else if (rf_gnt) state_next = START;
      START:   state_next = RUN;
      RUN:     if (rf_finish || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= IDLE;
      to_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (launch)
        to_cnt_reg <= '0;
      else if (state_reg == RUN)
        to_cnt_reg <= to_cnt_reg + 1'b1;
      if (timeout_hit)
        err_reg <= 1'b1;
    end
  end

  // A tick and a launch in the same cycle cancel; disabling drops the whole queue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_reg <= '0;
      ovf_reg  <= 1'b0;
    end else if (!mc_rf_en) begin
      pend_reg <= '0;
      ovf_reg  <= 1'b0;
    end else if (tick && !launch) begin
      if (pend_reg == PEND_MAX)
        ovf_reg <= 1'b1;
      else
        pend_reg <= pend_reg + 1'b1;
    end else if (!tick && launch && (pend_reg != '0)) begin
      pend_reg <= pend_reg - 1'b1;
    end
  end

  assign rf_req      = (state_reg != IDLE);
  assign rf_start    = launch;
  assign rf_busy     = (state_reg == START) || (state_reg == RUN);
  assign rf_pend_cnt = pend_reg;
  assign rf_overflow = ovf_reg;
  assign rf_err      = err_reg;

endmodule
